// File: rtl/judge_vote_ctrl.sv
// -----------------------------------------------------------------------------
// judge_vote_ctrl
//   Runs repeated vote sets against an upstream square judge. Each set issues
//   VOTE_NUM judgement rounds (judge_start pulse, wait for judge_dready), tallies
//   square verdicts and tracks the minimum edge width over the square rounds.
//   At the end of a set, a one-cycle result_valid pulse accompanies the
//   registered majority verdict (square_cnt >= VOTE_TH).
//
//   Optional feature macro: JUDGE_VOTE_TIMEOUT_EN
//     defined   - a round that sees no judge_dready within TIMEOUT cycles is
//                 accepted as non-square and flagged in timeout_err.
//     undefined - WAIT blocks indefinitely; timeout_err is tied low.
//
// Ports
//   clk             clock, posedge
//   rst_n           async active-low reset
//   en              level; high keeps vote sets running back to back
//   judge_start     one-cycle start pulse to the judge (KICK state)
//   judge_dready    one-cycle result pulse from the judge (sampled in WAIT only)
//   judge_is_square judge verdict, qualified by judge_dready
//   judge_width     judge minimum edge width, qualified by judge_dready
//   result_valid    one-cycle pulse when a set completes (DONE state)
//   result_square   majority verdict of the last completed set
//   result_width    min width over square rounds of last set (all-ones if none)
//   square_cnt      square rounds in the last completed set
//   timeout_err     any round of the last completed set timed out
// -----------------------------------------------------------------------------
module judge_vote_ctrl #(
  parameter int          WIDTH_W  = 18,
  parameter int          VOTE_NUM = 8,
  parameter int          VOTE_TH  = 5,
  parameter logic [31:0] TIMEOUT  = 32'd8000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               judge_start,
  input  logic               judge_dready,
  input  logic               judge_is_square,
  input  logic [WIDTH_W-1:0] judge_width,
  output logic               result_valid,
  output logic               result_square,
  output logic [WIDTH_W-1:0] result_width,
  output logic [7:0]         square_cnt,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, KICK, WAIT, DONE} state_t;

  // working state of the set in progress
  typedef struct packed {
    logic [7:0]         rnd;
    logic [7:0]         sq;
    logic [WIDTH_W-1:0] mn;
    logic               tmo;
  } work_t;

  localparam logic [7:0] VOTE_NUM_C = 8'(VOTE_NUM);
  localparam logic [7:0] VOTE_TH_C  = 8'(VOTE_TH);
  localparam work_t      WORK_CLR   = '{rnd: 8'd0, sq: 8'd0,
                                        mn: {WIDTH_W{1'b1}}, tmo: 1'b0};

  state_t state, state_nxt;
  work_t  wk, wk_nxt;
  logic   load_res;
  logic   tmo_hit;

`ifdef JUDGE_VOTE_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // fires on the TIMEOUT-th WAIT cycle without a dready, so the next KICK
  // lands exactly TIMEOUT cycles after WAIT was entered
  assign tmo_hit = (state == WAIT) && !judge_dready && (tmo_cnt == TIMEOUT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= 32'd0;
    else if (state != WAIT)       tmo_cnt <= 32'd0;
    else if (tmo_cnt != 32'hFFFF_FFFF) tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wk    <= '{rnd: 8'd0, sq: 8'd0, mn: {WIDTH_W{1'b1}}, tmo: 1'b0};
    end else begin
      state <= state_nxt;
      wk    <= wk_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wk_nxt       = wk;
    load_res     = 1'b0;
    judge_start  = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = KICK;
          wk_nxt    = WORK_CLR;
        end
      end
      KICK: begin
        judge_start = 1'b1;
        state_nxt   = en ? WAIT : IDLE;
      end
      WAIT: begin
        // en dropping wins over a coincident dready: the partial set is discarded
        if (!en) begin
          state_nxt = IDLE;
        end else if (judge_dready || tmo_hit) begin
          wk_nxt.rnd = wk.rnd + 8'd1;
          if (judge_dready && judge_is_square) begin
            wk_nxt.sq = wk.sq + 8'd1;
            if (judge_width < wk.mn) wk_nxt.mn = judge_width;
          end
          if (!judge_dready) wk_nxt.tmo = 1'b1;
          if (wk_nxt.rnd == VOTE_NUM_C) begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end else begin
            state_nxt = KICK;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (en) begin
          state_nxt = KICK;
          wk_nxt    = WORK_CLR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // results load on the edge entering DONE, so they are valid with result_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_square <= 1'b0;
      result_width  <= {WIDTH_W{1'b1}};
      square_cnt    <= 8'd0;
    end else if (load_res) begin
      result_square <= (wk_nxt.sq >= VOTE_TH_C);
      result_width  <= wk_nxt.mn;
      square_cnt    <= wk_nxt.sq;
    end
  end

`ifdef JUDGE_VOTE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        timeout_err <= 1'b0;
    else if (load_res) timeout_err <= wk_nxt.tmo;
  end
`else
  logic unused_wk_tmo;
  assign unused_wk_tmo = wk.tmo;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_judge_vote_ctrl.sv
// -----------------------------------------------------------------------------
// tb_judge_vote_ctrl
//   Directed bench for judge_vote_ctrl (VOTE_NUM=8, VOTE_TH=5, TIMEOUT=100).
//   Inputs driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_judge_vote_ctrl;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         judge_start;
  logic         judge_dready;
  logic         judge_is_square;
  logic [W-1:0] judge_width;
  logic         result_valid;
  logic         result_square;
  logic [W-1:0] result_width;
  logic [7:0]   square_cnt;
  logic         timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  judge_vote_ctrl #(.WIDTH_W(W), .VOTE_NUM(8), .VOTE_TH(5), .TIMEOUT(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .judge_start(judge_start), .judge_dready(judge_dready),
    .judge_is_square(judge_is_square), .judge_width(judge_width),
    .result_valid(result_valid), .result_square(result_square),
    .result_width(result_width), .square_cnt(square_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

`ifdef JUDGE_VOTE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input bit sq, input logic [W-1:0] w,
                         input logic [7:0] cnt, input bit to);
    chk({tag, "_square"}, {31'd0, result_square}, {31'd0, sq});
    chk({tag, "_width"},  {14'd0, result_width},  {14'd0, w});
    chk({tag, "_cnt"},    {24'd0, square_cnt},    {24'd0, cnt});
    chk({tag, "_tmo"},    {31'd0, timeout_err},   {31'd0, to});
  endtask

  // bounded wait for a judge_start pulse, sampled on falling edges
  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (judge_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("start_seen", {31'd0, ok}, 32'd1);
  endtask

  // one round; optional stray dready while in KICK
  task automatic do_round(input bit sq, input logic [W-1:0] w, input bit last,
                          input bit kick_glitch);
    wait_start();
    if (kick_glitch) begin
      judge_dready = 1'b1; judge_is_square = 1'b1; judge_width = 18'd1;
      @(negedge clk);
      judge_dready = 1'b0; judge_is_square = 1'b0; judge_width = '0;
    end
    @(negedge clk);
    judge_dready = 1'b1; judge_is_square = sq; judge_width = w;
    @(negedge clk);
    judge_dready = 1'b0; judge_is_square = 1'b0; judge_width = '0;
    chk(last ? "valid_at_end" : "valid_mid_set", {31'd0, result_valid}, {31'd0, last});
  endtask

  task automatic run_set(input logic [7:0] mask, input logic [W-1:0] ws [8],
                         input bit glitch);
    for (int i = 0; i < 8; i++) do_round(mask[i], ws[i], i == 7, glitch && i == 0);
  endtask

  initial begin
    logic [W-1:0] ws [8];
    bit           bad;
    int           cnt;

    rst_n = 1'b0; en = 1'b0;
    judge_dready = 1'b0; judge_is_square = 1'b0; judge_width = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_start", {31'd0, judge_start}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk_res("rst", 1'b0, 18'h3FFFF, 8'd0, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    // stray dready in IDLE
    judge_dready = 1'b1; judge_is_square = 1'b1; judge_width = 18'd2;
    @(negedge clk);
    judge_dready = 1'b0; judge_is_square = 1'b0; judge_width = '0;
    chk("idle_no_start", {31'd0, judge_start}, 32'd0);
    chk_res("idle_dready", 1'b0, 18'h3FFFF, 8'd0, 1'b0);

    // A: all square
    en = 1'b1;
    ws = '{18'd40, 18'd35, 18'd50, 18'd35, 18'd60, 18'd38, 18'd41, 18'd45};
    run_set(8'hFF, ws, 1'b0);
    chk_res("all_sq", 1'b1, 18'd35, 8'd8, 1'b0);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, result_valid}, 32'd0);
    chk_res("all_sq_hold", 1'b1, 18'd35, 8'd8, 1'b0);

    // B: 4 square / 4 non-square, stray dready in KICK of round 1
    ws = '{18'd100, 18'd5, 18'd20, 18'd5, 18'd30, 18'd5, 18'd40, 18'd5};
    run_set(8'b0101_0101, ws, 1'b1);
    chk_res("four_sq", 1'b0, 18'd20, 8'd4, 1'b0);

    // D: no square rounds
    ws = '{18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9, 18'd9};
    run_set(8'h00, ws, 1'b0);
    chk_res("no_sq", 1'b0, 18'h3FFFF, 8'd0, 1'b0);

    // C: exactly VOTE_TH square rounds
    ws = '{18'd7, 18'd1, 18'd9, 18'd1, 18'd3, 18'd12, 18'd1, 18'd8};
    run_set(8'b1011_0101, ws, 1'b0);
    chk_res("five_sq", 1'b1, 18'd3, 8'd5, 1'b0);

    // E: en dropped in WAIT of round 3
    do_round(1'b1, 18'd1, 1'b0, 1'b0);
    do_round(1'b1, 18'd1, 1'b0, 1'b0);
    wait_start();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_no_start", {31'd0, judge_start}, 32'd0);
    chk("abort_no_valid", {31'd0, result_valid}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      judge_dready = (i == 5); judge_is_square = (i == 5); judge_width = 18'd1;
      @(negedge clk);
      if (judge_start || result_valid) bad = 1'b1;
    end
    judge_dready = 1'b0; judge_is_square = 1'b0; judge_width = '0;
    chk("abort_quiet", {31'd0, bad}, 32'd0);
    chk_res("abort_hold", 1'b1, 18'd3, 8'd5, 1'b0);

    // F: fresh set after abort must start from cleared state
    en = 1'b1;
    ws = '{18'd50, 18'd60, 18'd70, 18'd80, 18'd90, 18'd55, 18'd2, 18'd2};
    run_set(8'b0011_1111, ws, 1'b0);
    chk_res("restart", 1'b1, 18'd50, 8'd6, 1'b0);

    // G: timeout in round 2
    if (TMO_ON) begin
      do_round(1'b1, 18'd10, 1'b0, 1'b0);
      wait_start();
      @(negedge clk);
      cnt = 0;
      while (!judge_start && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      chk("tmo_restart_dist", cnt, 32'd100);
      for (int i = 0; i < 6; i++) do_round(1'b1, 18'd20, i == 5, 1'b0);
      chk_res("tmo_set", 1'b1, 18'd10, 8'd7, 1'b1);
    end

    // H: async reset mid-WAIT
    wait_start();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", {31'd0, judge_start}, 32'd0);
    chk("arst_valid", {31'd0, result_valid}, 32'd0);
    chk_res("arst", 1'b0, 18'h3FFFF, 8'd0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
